frame_sequencer: RTL

Frame sequencer that schedules the envelope, length-counter and sweep updates of the pulse channels. It counts `apu_clk` cycles and emits single-cycle `qtr_clk` / `hlf_clk` strobes at the NES frame-counter step points, in either 4-step or 5-step mode. It also latches the frame-counter control register and raises the frame IRQ. It sits between the register-write decoder and every pulse instance.

---
 rtl/frame_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Counts apu_clk cycles and emits single-cycle quarter/half-frame strobes at
// the frame-counter step points (4-step or 5-step mode). Latches the frame
// control register and raises the frame IRQ.
// Optional feature macro: FRAME_IRQ_EN (IRQ / inhibit / irq_ack logic present
// when defined; frame_irq tied low otherwise).
// -----------------------------------------------------------------------------
module frame_sequencer #(
   parameter int Q1 = 3728,
   parameter int Q2 = 7456,
   parameter int Q3 = 11185,
   parameter int Q4 = 14914,
   parameter int Q5 = 18640
) (
   input  logic       apu_clk,
   input  logic       rst_n,
   input  logic       frame_we,
   input  logic [7:0] frame_data,
   input  logic       irq_ack,
   output logic       qtr_clk,
   output logic       hlf_clk,
   output logic       frame_irq,
   output logic [2:0] frame_step
);

   // Step positions narrowed to the counter width (Q5 fits in 15 bits).
   localparam logic [14:0] C_Q1 = 15'(Q1);
   localparam logic [14:0] C_Q2 = 15'(Q2);
   localparam logic [14:0] C_Q3 = 15'(Q3);
   localparam logic [14:0] C_Q4 = 15'(Q4);
   localparam logic [14:0] C_Q5 = 15'(Q5);

   logic [14:0] r_cnt;
   logic        r_mode;
   logic        r_qtr;
   logic        r_hlf;
   logic [2:0]  r_step;

   logic        w_hit1;
   logic        w_hit2;
   logic        w_hit3;
   logic        w_hit4;
   logic        w_hit5;
   logic        w_end;
   logic        w_qtr_hit;
   logic        w_hlf_hit;
   logic [14:0] w_cnt_next;
   logic [2:0]  w_step_next;

   // Step-point comparisons on the registered counter.
   assign w_hit1 = (r_cnt == C_Q1);
   assign w_hit2 = (r_cnt == C_Q2);
   assign w_hit3 = (r_cnt == C_Q3);
   assign w_hit4 = (r_cnt == C_Q4);
   assign w_hit5 = (r_cnt == C_Q5);

   // Last step of the frame: Q4 in 4-step mode, Q5 in 5-step mode. In 5-step
   // mode Q4 is a silent step (advances frame_step only).
   assign w_end     = r_mode ? w_hit5 : w_hit4;
   assign w_qtr_hit = w_hit1 | w_hit2 | w_hit3 | w_end;
   assign w_hlf_hit = w_hit2 | w_end;

   // Next counter value: a register write restarts the frame, the last step wraps.
   always_comb begin
      w_cnt_next = r_cnt + 15'd1;
      if (frame_we || w_end) begin
         w_cnt_next = '0;
      end
   end

   // Next debug step index: holds the last matched step, cleared when a new
   // frame begins (counter back at zero) or on a write.
   always_comb begin
      w_step_next = r_step;
      if (frame_we) begin
         w_step_next = 3'd0;
      end else if (r_cnt == 15'd0) begin
         w_step_next = 3'd0;
      end else if (w_hit1) begin
         w_step_next = 3'd1;
      end else if (w_hit2) begin
         w_step_next = 3'd2;
      end else if (w_hit3) begin
         w_step_next = 3'd3;
      end else if (w_hit4) begin
         w_step_next = 3'd4;
      end else if (w_hit5 && r_mode) begin
         w_step_next = 3'd5;
      end
   end

   // Counter, step index and mode bit.
   always_ff @(posedge apu_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_step <= 3'd0;
         r_mode <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_next;
         r_step <= w_step_next;
         if (frame_we) begin
            r_mode <= frame_data[7];
         end
      end
   end

   // Registered strobes; a write overrides any step match in the same cycle
   // and fires both strobes at once when entering 5-step mode.
   always_ff @(posedge apu_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_qtr <= 1'b0;
         r_hlf <= 1'b0;
      end else if (frame_we) begin
         r_qtr <= frame_data[7];
         r_hlf <= frame_data[7];
      end else begin
         r_qtr <= w_qtr_hit;
         r_hlf <= w_hlf_hit;
      end
   end

   assign qtr_clk    = r_qtr;
   assign hlf_clk    = r_hlf;
   assign frame_step = r_step;

`ifdef FRAME_IRQ_EN
   logic r_inhibit;
   logic r_irq;
   logic w_irq_set;
   logic w_unused;

   // IRQ is raised only at the 4-step Q4 point, never when a write lands on it.
   assign w_irq_set = !frame_we && !r_mode && w_hit4 && !r_inhibit;

   // IRQ inhibit bit follows the control register.
   always_ff @(posedge apu_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inhibit <= 1'b0;
      end else if (frame_we) begin
         r_inhibit <= frame_data[6];
      end
   end

   // IRQ flag: set wins over acknowledge; inhibit-write or ack clears.
   always_ff @(posedge apu_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq <= 1'b0;
      end else if (w_irq_set) begin
         r_irq <= 1'b1;
      end else if (frame_we && frame_data[6]) begin
         r_irq <= 1'b0;
      end else if (irq_ack) begin
         r_irq <= 1'b0;
      end
   end

   assign frame_irq = r_irq;
   assign w_unused  = &{1'b0, frame_data[5:0]};
`else
   logic w_unused;

   assign frame_irq = 1'b0;
   assign w_unused  = &{1'b0, frame_data[6:0], irq_ack};
`endif

endmodule
